// File: rtl/div8_fa_restoring.sv
`default_nettype none
// ============================================================================
// Module      : div8_fa_restoring
// Description : 8-bit unsigned restoring array divider built from full-adder
//               subtractor stages, with the quotient and remainder registered.
// Revision    : 1.0 - initial release
// ============================================================================
module div8_fa_restoring (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] SBC,
    input  logic [7:0] SC,
    output logic       out_valid,
    output logic [7:0] Q,
    output logic [7:0] R
);

    // Partial remainder entering each stage; entry 8 is the final remainder.
    logic [7:0] w_p [0:8];
    logic [7:0] w_q;
    logic       r_out_valid;
    logic [7:0] r_q;
    logic [7:0] r_r;

    assign w_p[0] = 8'h00;

    genvar s, b;
    generate
        for (s = 0; s < 8; s = s + 1) begin : g_stage
            logic [8:0] w_x;
            logic [9:0] w_cy;
            logic [7:0] w_d;
            logic       w_qb;

            assign w_x     = {w_p[s], SBC[7-s]};
            assign w_cy[0] = 1'b1;

            for (b = 0; b < 9; b = b + 1) begin : g_fa
                logic w_y;
                if (b < 8) begin : g_lo
                    assign w_y    = ~SC[b];
                    assign w_d[b] = w_x[b] ^ w_y ^ w_cy[b];
                end else begin : g_hi
                    // Divisor is zero-extended to 9 bits, so its inverted MSB is 1.
                    assign w_y = 1'b1;
                end
                assign w_cy[b+1] = (w_x[b] & w_y) | (w_cy[b] & (w_x[b] ^ w_y));
            end

            // Carry-out set means no borrow: keep the difference, else restore.
            assign w_qb       = w_cy[9];
            assign w_q[7-s]   = w_qb;
            assign w_p[s+1]   = (w_d & {8{w_qb}}) | (w_x[7:0] & {8{~w_qb}});
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_q         <= 8'h00;
            r_r         <= 8'h00;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_q <= w_q;
                r_r <= w_p[8];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Q         = r_q;
    assign R         = r_r;

endmodule
`default_nettype wire

// File: tb/tb_div8_fa_restoring.sv
`default_nettype none
// ============================================================================
// Module      : tb_div8_fa_restoring
// Description : Self-checking bench for div8_fa_restoring (directed + sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div8_fa_restoring;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] SBC;
    logic [7:0] SC;
    logic       out_valid;
    logic [7:0] Q;
    logic [7:0] R;

    int n_total;
    int n_bad;

    div8_fa_restoring u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .SBC       (SBC),
        .SC        (SC),
        .out_valid (out_valid),
        .Q         (Q),
        .R         (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[10];

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        SBC      = 8'd0;
        SC       = 8'd0;

        vecs[0] = '{8'd243, 8'd3,   8'd81,  8'd0};
        vecs[1] = '{8'd100, 8'd26,  8'd3,   8'd22};
        vecs[2] = '{8'd255, 8'd9,   8'd28,  8'd3};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0};
        vecs[4] = '{8'd50,  8'd91,  8'd0,   8'd50};
        vecs[5] = '{8'd231, 8'd6,   8'd38,  8'd3};
        vecs[6] = '{8'd77,  8'd0,   8'd255, 8'd77};
        vecs[7] = '{8'd0,   8'd5,   8'd0,   8'd0};
        vecs[8] = '{8'd200, 8'd1,   8'd200, 8'd0};
        vecs[9] = '{8'd37,  8'd37,  8'd1,   8'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {15'd0, out_valid}, 16'd0);
        chk("reset_qr", {Q, R}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back directed requests, one per cycle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            SBC      = vecs[i].a;
            SC       = vecs[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {15'd0, out_valid}, 16'd1);
            chk($sformatf("vec%0d_qr", i), {Q, R}, {vecs[i].q, vecs[i].r});
        end

        // Idle: valid drops, result holds.
        @(negedge clk);
        in_valid = 1'b0;
        SBC      = 8'd123;
        SC       = 8'd4;
        @(posedge clk);
        #1;
        chk("idle_valid", {15'd0, out_valid}, 16'd0);
        chk("idle_hold", {Q, R}, {8'd1, 8'd0});

        // Asynchronous reset mid-stream.
        @(negedge clk);
        in_valid = 1'b1;
        SBC      = 8'd243;
        SC       = 8'd3;
        @(posedge clk);
        #1;
        chk("pre_rst_qr", {Q, R}, {8'd81, 8'd0});
        SBC = 8'd100;
        SC  = 8'd26;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("async_rst_qr", {Q, R}, 16'h0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_valid", i), {15'd0, out_valid}, 16'd0);
            chk($sformatf("post_rst%0d_qr", i), {Q, R}, 16'h0000);
        end

        // Exhaustive sweep against a reference model.
        for (int a = 0; a < 256; a++) begin
            for (int d = 0; d < 256; d++) begin
                logic [7:0] eq;
                logic [7:0] er;
                @(negedge clk);
                in_valid = 1'b1;
                SBC      = a[7:0];
                SC       = d[7:0];
                if (d == 0) begin
                    eq = 8'hFF;
                    er = a[7:0];
                end else begin
                    eq = 8'(a / d);
                    er = 8'(a % d);
                end
                @(posedge clk);
                #1;
                chk($sformatf("sweep_%0d_%0d", a, d), {out_valid, 7'd0, Q, R} >> 0 == 0 ? 16'd0 : {Q, R}, {eq, er});
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("final_valid", {15'd0, out_valid}, 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
